// File: rtl/snn_pkg.sv
// Shared definitions for the spiking-neuron tile.
// Contents:
//   DEF_WINDOW_W / DEF_COUNT_W / DEF_ISI_W : default widths for the spike decoder
//   win_state_e                            : windowing FSM states
//   sat_inc()                              : saturating increment shared with neuron blocks
package snn_pkg;

    localparam int unsigned DEF_WINDOW_W = 8;
    localparam int unsigned DEF_COUNT_W  = 8;
    localparam int unsigned DEF_ISI_W    = 12;

    typedef enum logic {
        IDLE,
        COUNT
    } win_state_e;

    // Increment value, holding at max_value once reached. Callers cast
    // their narrower operands to 32 bits and truncate the result back.
    function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                            input logic [31:0] max_value);
        if (value >= max_value) begin
            return max_value;
        end
        return value + 32'd1;
    endfunction

endpackage

// File: rtl/spike_isi_tracker.sv
// Spike edge detector and inter-spike-interval (ISI) tracker.
// Ports:
//   clock, reset : rising-edge clock, synchronous active-high reset
//   enable       : ISI measurement runs while high, frozen while low
//   spike_in     : raw spike train
//   rise         : combinational rising-edge strobe for this cycle
//   isi_last     : last measured interval, including any update made this cycle
//   isi_sat      : pulses when the interval measured this cycle clipped at max
module spike_isi_tracker
    import snn_pkg::*;
#(
    parameter int unsigned ISI_W = DEF_ISI_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             spike_in,
    output logic             rise,
    output logic [ISI_W-1:0] isi_last,
    output logic             isi_sat
);

    localparam logic [ISI_W-1:0] ISI_MAX = '1;

    logic             spike_prev_q, spike_prev_d;
    logic             first_seen_q, first_seen_d;
    logic [ISI_W-1:0] isi_cnt_q,    isi_cnt_d;
    logic [ISI_W-1:0] isi_last_q,   isi_last_d;

    always_comb begin
        rise         = spike_in & ~spike_prev_q;
        spike_prev_d = spike_in;
        first_seen_d = first_seen_q;
        isi_cnt_d    = isi_cnt_q;
        isi_last_d   = isi_last_q;
        isi_sat      = 1'b0;

        if (enable) begin
            if (rise) begin
                if (first_seen_q) begin
                    // The interval is the counter plus the rise cycle itself.
                    if (isi_cnt_q == ISI_MAX) begin
                        isi_last_d = ISI_MAX;
                        isi_sat    = 1'b1;
                    end else begin
                        isi_last_d = isi_cnt_q + ISI_W'(1);
                    end
                end
                isi_cnt_d    = '0;
                first_seen_d = 1'b1;
            end else begin
                isi_cnt_d = ISI_W'(sat_inc(32'(isi_cnt_q), 32'(ISI_MAX)));
            end
        end

        // Expose the post-update value so a window ending on a rise captures it.
        isi_last = isi_last_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            spike_prev_q <= 1'b0;
            first_seen_q <= 1'b0;
            isi_cnt_q    <= '0;
            isi_last_q   <= '0;
        end else begin
            spike_prev_q <= spike_prev_d;
            first_seen_q <= first_seen_d;
            isi_cnt_q    <= isi_cnt_d;
            isi_last_q   <= isi_last_d;
        end
    end

endmodule

// File: rtl/spike_rate_decoder.sv
// Spike train decoder: counts spike rising edges over a programmable window
// and reports {rate, last ISI, saturation} through a one-entry valid/ready buffer.
// Ports:
//   clock, reset            : rising-edge clock, synchronous active-high reset
//   enable                  : run contiguous windows while high; low aborts the window
//   spike_in                : spike train; a multi-cycle high counts once
//   window_len              : window length, 0 means 2^WINDOW_W; sampled at window start
//   rate_out, isi_out       : buffered record of the last accepted window
//   sat_out                 : rate or ISI saturated within that record
//   out_valid, out_ready    : output handshake
//   overrun                 : sticky, a completed window was dropped
module spike_rate_decoder
    import snn_pkg::*;
#(
    parameter int unsigned WINDOW_W = DEF_WINDOW_W,
    parameter int unsigned COUNT_W  = DEF_COUNT_W,
    parameter int unsigned ISI_W    = DEF_ISI_W
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable,
    input  logic                spike_in,
    input  logic [WINDOW_W-1:0] window_len,
    output logic [COUNT_W-1:0]  rate_out,
    output logic [ISI_W-1:0]    isi_out,
    output logic                sat_out,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                overrun
);

    localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

    logic             rise;
    logic [ISI_W-1:0] isi_last;
    logic             isi_sat;

    spike_isi_tracker #(
        .ISI_W(ISI_W)
    ) u_isi (
        .clock   (clock),
        .reset   (reset),
        .enable  (enable),
        .spike_in(spike_in),
        .rise    (rise),
        .isi_last(isi_last),
        .isi_sat (isi_sat)
    );

    win_state_e          state_q,   state_d;
    logic [WINDOW_W-1:0] timer_q,   timer_d;
    logic [COUNT_W-1:0]  count_q,   count_d;
    logic                win_sat_q, win_sat_d;
    logic [COUNT_W-1:0]  rate_q,    rate_d;
    logic [ISI_W-1:0]    isi_q,     isi_d;
    logic                sat_q,     sat_d;
    logic                valid_q,   valid_d;
    logic                overrun_q, overrun_d;

    logic                capture;
    logic [COUNT_W-1:0]  cnt_next;
    logic                sat_next;

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        count_d   = count_q;
        win_sat_d = win_sat_q;
        rate_d    = rate_q;
        isi_d     = isi_q;
        sat_d     = sat_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        capture   = 1'b0;
        cnt_next  = count_q;
        sat_next  = win_sat_q | isi_sat;

        if (rise) begin
            if (count_q == COUNT_MAX) begin
                sat_next = 1'b1;
            end else begin
                cnt_next = COUNT_W'(sat_inc(32'(count_q), 32'(COUNT_MAX)));
            end
        end

        unique case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d   = COUNT;
                    // window_len - 1 wraps 0 to all-ones, i.e. 2^WINDOW_W cycles.
                    timer_d   = window_len - WINDOW_W'(1);
                    count_d   = '0;
                    win_sat_d = 1'b0;
                end
            end
            COUNT: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (timer_q == '0) begin
                    // Last cycle: hand off the result, restart with no gap cycle.
                    capture   = 1'b1;
                    timer_d   = window_len - WINDOW_W'(1);
                    count_d   = '0;
                    win_sat_d = 1'b0;
                end else begin
                    timer_d   = timer_q - WINDOW_W'(1);
                    count_d   = cnt_next;
                    win_sat_d = sat_next;
                end
            end
            default: state_d = IDLE;
        endcase

        if (capture) begin
            if (!valid_q || out_ready) begin
                rate_d  = cnt_next;
                isi_d   = isi_last;
                sat_d   = sat_next;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            count_q   <= '0;
            win_sat_q <= 1'b0;
            rate_q    <= '0;
            isi_q     <= '0;
            sat_q     <= 1'b0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            count_q   <= count_d;
            win_sat_q <= win_sat_d;
            rate_q    <= rate_d;
            isi_q     <= isi_d;
            sat_q     <= sat_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign rate_out  = rate_q;
    assign isi_out   = isi_q;
    assign sat_out   = sat_q;
    assign out_valid = valid_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Bench for spike_rate_decoder: two instances (COUNT_W=8 and COUNT_W=6) share
// stimulus; a window-level reference model pushes expected records into one
// queue per instance and a negedge monitor compares whatever the DUTs present.
module tb_spike_rate_decoder;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       spike_in;
    logic [7:0] window_len;
    logic       out_ready;

    logic [7:0]  rate8;
    logic [11:0] isi8;
    logic        sat8, valid8, ovr8;
    logic [5:0]  rate6;
    logic [11:0] isi6;
    logic        sat6, valid6, ovr6;

    spike_rate_decoder dut8 (
        .clock(clk), .reset(reset), .enable(enable), .spike_in(spike_in),
        .window_len(window_len), .rate_out(rate8), .isi_out(isi8), .sat_out(sat8),
        .out_valid(valid8), .out_ready(out_ready), .overrun(ovr8)
    );

    spike_rate_decoder #(.COUNT_W(6)) dut6 (
        .clock(clk), .reset(reset), .enable(enable), .spike_in(spike_in),
        .window_len(window_len), .rate_out(rate6), .isi_out(isi6), .sat_out(sat6),
        .out_valid(valid6), .out_ready(out_ready), .overrun(ovr6)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int rate;
        int isi;
        int sat;
    } rec_t;

    rec_t q8[$];
    rec_t q6[$];

    int n_tests = 0;
    int n_fail  = 0;
    bit started = 0;

    // Reference model state (spec-level quantities, plain integers)
    int m_prev, m_t, m_have, m_last_t, m_isi_last;
    int m_idle, m_wlen, m_pos, m_rises, m_clip;
    int m_valid, m_overrun;

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_prev = 0; m_t = 0; m_have = 0; m_last_t = 0; m_isi_last = 0;
        m_idle = 1; m_wlen = 0; m_pos = 0; m_rises = 0; m_clip = 0;
        m_valid = 0; m_overrun = 0;
        q8.delete();
        q6.delete();
    endtask

    // Drive one cycle's inputs, predict the effect of the coming edge, wait
    // for it, then publish the predicted buffer state. Returns at edge + 1.
    task automatic cyc(input bit en, input bit spk, input int wl, input bit rdy);
        bit   rise, clip_now, cap;
        int   iv, nv, no;
        rec_t r;
        reset = 1'b0; enable = en; spike_in = spk; window_len = 8'(wl); out_ready = rdy;

        rise = spk && (m_prev == 0);
        m_prev = spk;
        clip_now = 0;
        cap = 0;
        if (en) begin
            m_t++;
            if (rise) begin
                if (m_have != 0) begin
                    iv = m_t - m_last_t;
                    if (iv > 4095) begin
                        iv = 4095;
                        clip_now = 1;
                    end
                    m_isi_last = iv;
                end
                m_last_t = m_t;
                m_have = 1;
            end
        end

        if (!en) begin
            m_idle = 1;
        end else if (m_idle != 0) begin
            m_idle = 0;
            m_wlen = (wl == 0) ? 256 : wl;
            m_pos = 0; m_rises = 0; m_clip = 0;
        end else begin
            m_pos++;
            if (rise) m_rises++;
            if (clip_now) m_clip = 1;
            if (m_pos == m_wlen) begin
                cap = 1;
                nv = 0;
            end
        end

        nv = m_valid;
        no = m_overrun;
        if (cap) begin
            if (m_valid == 0 || rdy) begin
                r.isi  = m_isi_last;
                r.rate = (m_rises > 255) ? 255 : m_rises;
                r.sat  = (m_clip != 0 || m_rises > 255) ? 1 : 0;
                q8.push_back(r);
                r.rate = (m_rises > 63) ? 63 : m_rises;
                r.sat  = (m_clip != 0 || m_rises > 63) ? 1 : 0;
                q6.push_back(r);
                nv = 1;
            end else begin
                no = 1;
            end
            m_wlen = (wl == 0) ? 256 : wl;
            m_pos = 0; m_rises = 0; m_clip = 0;
        end else if (m_valid != 0 && rdy) begin
            nv = 0;
        end

        @(posedge clk);
        m_valid = nv;
        m_overrun = no;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; enable = 1'b0; spike_in = 1'b0; out_ready = 1'b0; window_len = '0;
        repeat (2) @(posedge clk);
        model_clear();
        #1;
        reset = 1'b0;
        started = 1;
        @(negedge clk);
        chk("rst_rate8", rate8, 0);
        chk("rst_isi8", isi8, 0);
        chk("rst_sat8", sat8, 0);
        chk("rst_valid8", valid8, 0);
        chk("rst_ovr8", ovr8, 0);
        chk("rst_rate6", rate6, 0);
        chk("rst_valid6", valid6, 0);
        chk("rst_ovr6", ovr6, 0);
        @(posedge clk);
        #1;
    endtask

    // Monitor: buffer flags every cycle, record contents whenever presented,
    // popping on the cycle the record is accepted.
    always @(negedge clk) begin
        if (started && !reset) begin
            chk("valid8", valid8, m_valid);
            chk("valid6", valid6, m_valid);
            chk("overrun8", ovr8, m_overrun);
            chk("overrun6", ovr6, m_overrun);
            if (valid8) begin
                if (q8.size() == 0) begin
                    chk("rec8_expected", 0, 1);
                end else begin
                    chk("rec8_rate", rate8, q8[0].rate);
                    chk("rec8_isi", isi8, q8[0].isi);
                    chk("rec8_sat", sat8, q8[0].sat);
                    if (out_ready) void'(q8.pop_front());
                end
            end
            if (valid6) begin
                if (q6.size() == 0) begin
                    chk("rec6_expected", 0, 1);
                end else begin
                    chk("rec6_rate", rate6, q6[0].rate);
                    chk("rec6_isi", isi6, q6[0].isi);
                    chk("rec6_sat", sat6, q6[0].sat);
                    if (out_ready) void'(q6.pop_front());
                end
            end
        end
    end

    initial begin
        reset = 1'b1; enable = 1'b0; spike_in = 1'b0; out_ready = 1'b0; window_len = '0;
        model_clear();

        // 1: spikes at window cycles 2,5,8 of a 10-cycle window, then a quiet window
        do_reset();
        cyc(1, 0, 10, 1);
        for (int c = 1; c <= 10; c++) cyc(1, (c == 2 || c == 5 || c == 8), 10, 1);
        chk("t1_valid", valid8, 1);
        chk("t1_rate", rate8, 3);
        chk("t1_isi", isi8, 3);
        chk("t1_sat", sat8, 0);
        for (int c = 1; c <= 10; c++) cyc(1, 0, 10, 1);
        chk("t1_rate_w2", rate8, 0);
        repeat (3) cyc(0, 0, 10, 1);

        // 2: one long pulse counts once, no interval yet
        do_reset();
        cyc(1, 0, 10, 1);
        for (int c = 1; c <= 10; c++) cyc(1, (c >= 3 && c <= 8), 10, 1);
        chk("t2_rate", rate8, 1);
        chk("t2_isi", isi8, 0);
        repeat (2) cyc(0, 0, 10, 1);

        // 3: 256-cycle window, toggling spike -> 128 rises; 6-bit instance clips
        do_reset();
        cyc(1, 0, 0, 1);
        for (int c = 1; c <= 256; c++) cyc(1, (c % 2) == 1, 0, 1);
        chk("t3_rate8", rate8, 128);
        chk("t3_sat8", sat8, 0);
        chk("t3_rate6", rate6, 63);
        chk("t3_sat6", sat6, 1);
        chk("t3_isi", isi8, 2);
        repeat (2) cyc(0, 0, 0, 1);

        // 4: consumer stalled over two window ends, then one accept cycle
        do_reset();
        cyc(1, 0, 4, 0);
        for (int c = 1; c <= 4; c++) cyc(1, (c == 1), 4, 0);
        chk("t4_valid", valid8, 1);
        chk("t4_ovr_first", ovr8, 0);
        for (int c = 1; c <= 4; c++) cyc(1, (c == 1 || c == 3), 4, 0);
        chk("t4_ovr", ovr8, 1);
        chk("t4_held_rate", rate8, 1);
        cyc(0, 0, 4, 1);
        chk("t4_valid_fall", valid8, 0);
        chk("t4_hold_rate", rate8, 1);
        repeat (3) cyc(0, 0, 4, 1);
        chk("t4_ovr_sticky", ovr8, 1);

        // 5: abort at window cycle 4, re-enable 3 cycles later
        do_reset();
        cyc(1, 0, 8, 1);
        for (int c = 1; c <= 3; c++) cyc(1, (c == 2), 8, 1);
        repeat (3) cyc(0, 0, 8, 1);
        chk("t5_no_record", valid8, 0);
        cyc(1, 0, 8, 1);
        for (int c = 1; c <= 8; c++) cyc(1, (c == 3 || c == 6), 8, 1);
        chk("t5_rate", rate8, 2);
        chk("t5_isi", isi8, 3);
        repeat (2) cyc(0, 0, 8, 1);

        // 6: reset mid-window while a record is held, then one full window
        do_reset();
        cyc(1, 0, 5, 0);
        for (int c = 1; c <= 5; c++) cyc(1, (c == 1), 5, 0);
        chk("t6_valid_before", valid8, 1);
        cyc(1, 0, 5, 0);
        cyc(1, 1, 5, 0);
        do_reset();
        cyc(1, 0, 5, 1);
        for (int c = 1; c <= 4; c++) cyc(1, (c == 2), 5, 1);
        chk("t6_not_early", valid8, 0);
        cyc(1, 0, 5, 1);
        chk("t6_valid", valid8, 1);
        chk("t6_rate", rate8, 1);
        repeat (2) cyc(0, 0, 5, 1);

        // ISI clip: interval of 4098 enabled cycles saturates at 4095
        do_reset();
        for (int i = 0; i <= 4200; i++) cyc(1, (i == 1 || i == 4099), 0, 1);
        repeat (2) cyc(0, 0, 0, 1);

        // Randomised traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = int'($urandom_range(0, 15));
            cyc($urandom_range(0, 39) != 0, $urandom_range(0, 2) == 0,
                (r == 0) ? 0 : 1 + (r % 9), $urandom_range(0, 3) != 0);
        end

        repeat (6) cyc(0, 0, 1, 1);
        chk("drain8", q8.size(), 0);
        chk("drain6", q6.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spike_rate_decoder.md
Name: spike_rate_decoder

Overview:
Receiving end of the neuron spike interface. It converts a 1-bit spike train, such as the HH/LIF neuron `spike` output, back into numbers: a spike count (rate) over a programmable window and the most recent inter-spike interval (ISI). Each window's result is delivered through a one-entry valid/ready output buffer. The block sits downstream of a neuron in the tile, or feeds the next layer's `current_in`.

Parameters:
WINDOW_W, 8, width of window_len; window length range 1..2^WINDOW_W cycles
COUNT_W, 8, width of rate_out; spike count saturates at 2^COUNT_W-1
ISI_W, 12, width of isi_out; interval saturates at 2^ISI_W-1

Ports:
clock  in  1  single clock; all logic rising-edge
reset  in  1  synchronous, active-high reset
enable  in  1  run windows while high; low aborts the current window
spike_in  in  1  spike train, synchronous to clock; a multi-cycle high counts as one spike
window_len  in  WINDOW_W  window length in cycles; 0 means 2^WINDOW_W; sampled at each window start
rate_out  out  COUNT_W  rising edges counted in the completed window
isi_out  out  ISI_W  last measured ISI at the window end; 0 = no interval measured yet
sat_out  out  1  rate or ISI saturated within this record
out_valid  out  1  output record valid
out_ready  in  1  consumer accepts the record when out_valid && out_ready
overrun  out  1  sticky: a completed window was dropped; cleared only by reset

Behaviour:
- Reset values: rate_out=0, isi_out=0, sat_out=0, out_valid=0, overrun=0; FSM=IDLE; spike_d=0; ISI counter=0; first_seen=0; isi_last=0.
- Edge detect: rise = spike_in & ~spike_d. spike_d is registered every cycle regardless of FSM state.
- FSM IDLE:
  - enable=1 → latch N = window_len (0 → 2^WINDOW_W); timer=N-1; count=0; go to COUNT.
  - The first counted cycle is the cycle after the latch.
- FSM COUNT:
  - Each cycle: if rise, count += 1, saturating at max and setting the window sat flag.
  - Timer decrements. On the cycle with timer==0 (last cycle, i.e. the Nth), capture fires.
  - The capture includes any rise in that last cycle.
  - Then re-latch window_len and start the next window with no gap cycle (windows are contiguous).
- Abort:
  - enable=0 in COUNT → go to IDLE next cycle; the partial window is discarded.
  - The ISI state is kept; the output buffer is untouched.
- ISI (runs whenever enable=1; frozen when enable=0):
  - On rise: if first_seen, isi_last = min(isi_cnt+1, max), and sat is set if it clips; then isi_cnt=0 and first_seen=1.
  - Otherwise isi_cnt increments, saturating.
  - Example: rises at cycles 10 and 15 → isi_last=5.
- Capture into the output buffer, evaluated at the last cycle of a window:
  - out_valid=0, or out_valid && out_ready → load {count, isi_last, sat}; out_valid=1 the next cycle. Accept and load in the same cycle is legal and keeps out_valid high with no bubble.
  - out_valid && !out_ready → new result dropped; buffer held; overrun=1.
- Latency: out_valid rises exactly 1 cycle after a window's last cycle.
- Buffered outputs are stable while out_valid && !out_ready.
- Accept without capture: out_valid=0 the next cycle; data holds its last value.
- Reset in any state takes priority over every other event; everything returns to the reset values the next cycle.

Decomposition:
- Package snn_pkg:
  - FSM state enum {IDLE, COUNT}
  - default width constants: WINDOW_W, COUNT_W, ISI_W
  - saturating-increment function shared with neuron blocks
- Sub-module spike_isi_tracker:
  - contains the edge detect, ISI counter, first_seen and isi_last
  - outputs rise, isi_last and isi_sat
- Windowing FSM and the output buffer stay in the top module.

Test Plan:
1. reset then enable=1, window_len=10, one-cycle spikes at window cycles 2, 5, 8; out_ready=1 → out_valid at cycle 11 with rate_out=3, isi_out=3, sat_out=0; next window back-to-back.
2. spike_in held high for 6 cycles inside a 10-cycle window → rate_out=1; isi_out=0 (first spike only).
3. COUNT_W=8, window_len=0 (256 cycles), spike toggling every cycle (128 rises) → rate_out=128; same run with COUNT_W=6 → rate_out=63, sat_out=1.
4. out_ready=0 across two window ends → first record held unchanged, overrun=1 after the second; then out_ready=1 for one cycle → out_valid falls and overrun stays 1 until reset.
5. enable dropped at window cycle 4, re-raised 3 cycles later → no record emitted for the aborted window; the next full window reports only its own spikes.
6. reset asserted mid-window with out_valid=1 → all outputs 0 the next cycle; first record after re-enable is exactly one full window late.
